// File: rtl/ram_loader_if.sv
// Byte-stream handshake between the host-side source and the RAM loader.
interface ram_loader_if #(
  parameter int contentSize = 8
) ();
  logic [contentSize-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ram_loader.sv
// Streams an image into the RAM write port, then reads it back and compares
// byte sums to confirm the load.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | accepting stream bytes and writing them at wptr
// SETTLE | two-cycle wait for RAM write-to-read visibility
// VERIFY | reading back 0..len-1 and summing
// DONE   | load finished; error holds the checksum result
module ram_loader #(
  parameter int addrSize    = 9,
  parameter int contentSize = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addrSize:0]      len,
  ram_loader_if.slave            s,
  output logic [addrSize-1:0]    addr_in,
  output logic [contentSize-1:0] dataIn,
  output logic                   write_rq,
  output logic [addrSize-1:0]    addr_out,
  input  logic [contentSize-1:0] dataOut,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_VERIFY, S_DONE
  } state_t;

  localparam logic [addrSize:0] FULL = {1'b1, {addrSize{1'b0}}};
  localparam logic [addrSize:0] ONE  = {{addrSize{1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [addrSize:0]      len_q, len_d;
  logic [addrSize:0]      wptr_q, wptr_d;
  logic [addrSize:0]      rptr_q, rptr_d;
  logic [addrSize:0]      cnt_q, cnt_d;
  logic [contentSize-1:0] wsum_q, wsum_d;
  logic [contentSize-1:0] rsum_q, rsum_d;
  logic [contentSize-1:0] dlast_q, dlast_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   accept;

  assign accept = (state_q == S_LOAD) && s.in_valid;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
    dlast_d = dlast_q;
    error_d = error_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d   = (len > FULL) ? FULL : len;
          wptr_d  = '0;
          rptr_d  = '0;
          wsum_d  = '0;
          rsum_d  = '0;
          error_d = 1'b0;
          if (len == '0) begin
            state_d = S_SETTLE;
            cnt_d   = ONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          wptr_d  = wptr_q + ONE;
          wsum_d  = wsum_q + s.in_data;
          dlast_d = s.in_data;
          if (wptr_d == len_q) begin
            state_d = S_SETTLE;
            cnt_d   = ONE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          // An empty load has nothing to read back; both sums are still zero.
          if (len_q == '0) begin
            state_d = S_DONE;
            error_d = (wsum_q != rsum_q);
          end else begin
            state_d = S_VERIFY;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_VERIFY: begin
        rsum_d = rsum_q + dataOut;
        rptr_d = rptr_q + ONE;
        if (rptr_d == len_q) begin
          state_d = S_DONE;
          error_d = (wsum_q != rsum_d);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_SETTLE) || (state_d == S_VERIFY);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      wsum_q  <= '0;
      rsum_q  <= '0;
      dlast_q <= '0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
      dlast_q <= dlast_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Write side is combinational so an accepted byte lands in the same cycle.
  assign s.in_ready = (state_q == S_LOAD);
  assign write_rq   = accept;
  assign addr_in    = wptr_q[addrSize-1:0];
  assign dataIn     = (state_q == S_LOAD) ? s.in_data : dlast_q;
  assign addr_out   = (state_q == S_VERIFY) ? rptr_q[addrSize-1:0] : '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural RAM and write monitor.
module tb_ram_loader;
  localparam int AW = 9;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [AW:0] len = '0;
  logic [AW-1:0] addr_in, addr_out;
  logic [DW-1:0] dataIn, dataOut;
  logic write_rq, busy, done, error;

  ram_loader_if #(.contentSize(DW)) sif ();

  ram_loader #(.addrSize(AW), .contentSize(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .s(sif),
    .addr_in(addr_in), .dataIn(dataIn), .write_rq(write_rq),
    .addr_out(addr_out), .dataOut(dataOut),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int wr_cnt, wr_seq_bad, wr_last, overlap;
  logic mon_clr = 1'b0;
  logic corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [7:0] tbl [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int nchk = 0;
  int nerr = 0;

  assign dataOut = mem[addr_out] ^ ((corrupt_en && addr_out == corrupt_addr) ? 8'h01 : 8'h00);

  // RAM write port plus address-sequence monitor (expected address = write index)
  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt <= 0; wr_seq_bad <= 0; wr_last <= -1;
    end else if (write_rq) begin
      mem[addr_in] <= dataIn;
      if (int'(addr_in) != wr_cnt) wr_seq_bad <= wr_seq_bad + 1;
      wr_cnt  <= wr_cnt + 1;
      wr_last <= int'(addr_in);
    end
  end

  always @(negedge clk) if (reset && done && busy) overlap <= overlap + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int mode, input int idx);
    if (mode == 0) return (idx < 4) ? tbl[idx] : 8'h00;
    if (mode == 1) return idx[7:0];
    return 8'hA5;
  endfunction

  task automatic do_load(input int n_offer, input logic [AW:0] lenv, input int mode,
                         input int gap_n, input int pulse_at, input int abort_at,
                         output int cycles, output int any_ready, output int gap_wr,
                         output int wspan);
    int idx, gap_left, wfirst, wlast;
    bit gap_done, acc;
    mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
    idx = 0; gap_left = 0; gap_done = 0; wfirst = -1; wlast = -1;
    any_ready = 0; gap_wr = 0; cycles = 0;
    len = lenv; start = 1'b1; sif.in_valid = 1'b0; sif.in_data = '0;
    #1 chk("busy_pre", busy, 0);
    @(posedge clk); #1 start = 1'b0; cycles = 1;
    chk("busy_rise", busy, 1);
    while (!done && cycles < 3000 && !(abort_at >= 0 && idx == abort_at)) begin
      start = (pulse_at == cycles);
      sif.in_valid = (gap_left > 0) ? 1'b0 : (idx < n_offer);
      sif.in_data  = byte_of(mode, idx);
      #1;
      if (sif.in_ready) any_ready = 1;
      if (write_rq) begin
        if (wfirst < 0) wfirst = cycles;
        wlast = cycles;
        if (gap_left > 0) gap_wr = 1;
      end
      acc = sif.in_valid && sif.in_ready;
      @(posedge clk); #1;
      cycles++;
      if (gap_left > 0) gap_left--;
      if (acc) begin
        idx++;
        if (idx == 2 && gap_n > 0 && !gap_done) begin
          gap_left = gap_n; gap_done = 1;
        end
      end
    end
    start = 1'b0; sif.in_valid = 1'b0;
    if (abort_at < 0) chk("timeout", cycles < 3000, 1);
    wspan = (wfirst < 0) ? 0 : wlast - wfirst + 1;
  endtask

  initial begin
    int cyc, rdy, gw, span;
    sif.in_valid = 1'b0; sif.in_data = '0;
    #2;
    chk("rst_outs", {sif.in_ready, write_rq, busy, done, error, addr_in, dataIn, addr_out}, 0);
    @(posedge clk); #1 reset = 1'b1;

    // basic 4-byte load
    do_load(4, 10'd4, 0, 0, -1, -1, cyc, rdy, gw, span);
    chk("t1_cycles", cyc, 11);
    chk("t1_done", done, 1);
    chk("t1_error", error, 0);
    chk("t1_wcnt", wr_cnt, 4);
    chk("t1_span", span, 4);
    chk("t1_seq", wr_seq_bad, 0);
    chk("t1_mem2", mem[2], 8'h33);

    // 3-cycle valid gap after byte 2
    do_load(4, 10'd4, 0, 3, -1, -1, cyc, rdy, gw, span);
    chk("t2_cycles", cyc, 14);
    chk("t2_gapwr", gw, 0);
    chk("t2_span", span, 7);
    chk("t2_error", error, 0);
    chk("t2_data", {mem[0], mem[1], mem[2], mem[3]}, 32'h11223344);

    // start pulsed during VERIFY is ignored
    do_load(4, 10'd4, 0, 0, 8, -1, cyc, rdy, gw, span);
    chk("t3_cycles", cyc, 11);
    chk("t3_error", error, 0);
    chk("t3_wcnt", wr_cnt, 4);

    // read-back corruption at address 1
    corrupt_en = 1'b1; corrupt_addr = 9'd1;
    do_load(4, 10'd4, 0, 0, -1, -1, cyc, rdy, gw, span);
    corrupt_en = 1'b0;
    chk("t4_cycles", cyc, 11);
    chk("t4_error", error, 1);

    // full depth load
    do_load(512, 10'd512, 1, 0, -1, -1, cyc, rdy, gw, span);
    chk("t5_cycles", cyc, 1027);
    chk("t5_error", error, 0);
    chk("t5_wcnt", wr_cnt, 512);
    chk("t5_last", wr_last, 511);
    chk("t5_seq", wr_seq_bad, 0);
    chk("t5_mem511", mem[511], 8'hFF);

    // oversize len saturates to full depth
    do_load(600, 10'h3FF, 1, 0, -1, -1, cyc, rdy, gw, span);
    chk("t6_cycles", cyc, 1027);
    chk("t6_error", error, 0);
    chk("t6_wcnt", wr_cnt, 512);
    chk("t6_last", wr_last, 511);
    chk("t6_seq", wr_seq_bad, 0);

    // empty load
    do_load(1, 10'd0, 0, 0, -1, -1, cyc, rdy, gw, span);
    chk("t7_cycles", cyc, 3);
    chk("t7_ready", rdy, 0);
    chk("t7_wcnt", wr_cnt, 0);
    chk("t7_done", done, 1);
    chk("t7_error", error, 0);

    // reset mid-load after byte 2, then single-byte load
    do_load(4, 10'd4, 0, 0, -1, 2, cyc, rdy, gw, span);
    chk("t8_inload", busy, 1);
    reset = 1'b0;
    #1 chk("t8_rst_outs", {sif.in_ready, write_rq, busy, done, error, addr_in, dataIn, addr_out}, 0);
    @(posedge clk); #1 reset = 1'b1;
    do_load(1, 10'd1, 2, 0, -1, -1, cyc, rdy, gw, span);
    chk("t8_cycles", cyc, 5);
    chk("t8_wcnt", wr_cnt, 1);
    chk("t8_last", wr_last, 0);
    chk("t8_mem0", mem[0], 8'hA5);
    chk("t8_error", error, 0);

    chk("busy_done_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
